// File: rtl/fir_decimator.sv
// Decimator behind fir_filter. It keeps one enabled sample per DECIM group and
// buffers kept samples in a first-word-fall-through FIFO with a sticky overflow flag.
module fir_decimator #(
  parameter int DATA_WIDTH = 8,
  parameter int DECIM      = 4,
  parameter int PHASE      = 0,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          ena_i,
  input  logic signed [DATA_WIDTH-1:0]  data_i,
  input  logic                          clear_i,
  output logic signed [DATA_WIDTH-1:0]  data_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   count_o,
  output logic                          overflow_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;

  logic [PW-1:0]                phase;
  logic [AW-1:0]                wr_ptr;
  logic [AW-1:0]                rd_ptr;
  logic signed [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic                         keep;
  logic                         full;
  logic                         pop;
  logic                         push;

  // With DECIM=1 the phase stays at 0, so keep reduces to ena_i.
  assign keep    = ena_i && (phase == PW'(PHASE));
  assign full    = (count_o == CW'(FIFO_DEPTH));
  assign valid_o = (count_o != '0);
  assign pop     = valid_o && ready_i;
  assign push    = keep && (!full || pop);

  // NOTE: the storage array has no reset; emptiness is tracked by count_o, so stale
  // contents are never observed and the array can map onto plain RAM.
  always_ff @(posedge clk_i) begin
    if (push && !clear_i) begin
      mem[wr_ptr] <= data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      phase      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_o    <= '0;
      overflow_o <= 1'b0;
      data_o     <= '0;
    end else if (clear_i) begin
      phase      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_o    <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (ena_i) begin
        phase <= (phase == PW'(DECIM - 1)) ? '0 : phase + PW'(1);
      end
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_o <= count_o + CW'(1);
        2'b01:   count_o <= count_o - CW'(1);
        default: count_o <= count_o;
      endcase
      if (keep && full && !pop) begin
        overflow_o <= 1'b1;
      end
      // Registered head: load the next entry, or bypass data_i when it becomes the head.
      if (pop) begin
        if (count_o == CW'(1)) begin
          if (push) begin
            data_o <= data_i;
          end
        end else begin
          data_o <= mem[rd_ptr + AW'(1)];
        end
      end else if (!valid_o && push) begin
        data_o <= data_i;
      end
    end
  end

endmodule

// File: tb/tb_fir_decimator.sv
// Directed bench for fir_decimator: three instances (DECIM=4/PHASE=0, DECIM=4/PHASE=3,
// DECIM=1) share one stimulus stream; each step checks the instance it targets.
module tb_fir_decimator;

  logic              clk = 1'b0;
  logic              rst;
  logic              ena;
  logic signed [7:0] data;
  logic              clear;
  logic              ready;

  logic signed [7:0] d_a, d_b, d_c;
  logic              v_a, v_b, v_c;
  logic [4:0]        c_a, c_b, c_c;
  logic              o_a, o_b, o_c;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  fir_decimator #(.DATA_WIDTH(8), .DECIM(4), .PHASE(0), .FIFO_DEPTH(16)) u_d4p0 (
    .clk_i(clk), .rst_i(rst), .ena_i(ena), .data_i(data), .clear_i(clear),
    .data_o(d_a), .valid_o(v_a), .ready_i(ready), .count_o(c_a), .overflow_o(o_a));

  fir_decimator #(.DATA_WIDTH(8), .DECIM(4), .PHASE(3), .FIFO_DEPTH(16)) u_d4p3 (
    .clk_i(clk), .rst_i(rst), .ena_i(ena), .data_i(data), .clear_i(clear),
    .data_o(d_b), .valid_o(v_b), .ready_i(ready), .count_o(c_b), .overflow_o(o_b));

  fir_decimator #(.DATA_WIDTH(8), .DECIM(1), .PHASE(0), .FIFO_DEPTH(16)) u_d1 (
    .clk_i(clk), .rst_i(rst), .ena_i(ena), .data_i(data), .clear_i(clear),
    .data_o(d_c), .valid_o(v_c), .ready_i(ready), .count_o(c_c), .overflow_o(o_c));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    int en_idx;
    rst   = 1'b1;
    ena   = 1'b0;
    data  = '0;
    clear = 1'b0;
    ready = 1'b0;
    tick();
    tick();
    check("rst_count", c_a, 0);
    check("rst_valid", v_a, 0);
    check("rst_ovf",   o_a, 0);
    check("rst_data",  d_a, 0);
    rst = 1'b0;

    // Continuous enable, consumer always ready.
    ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ena  = 1'b1;
      data = 8'(i);
      tick();
      check("p0_valid", v_a, (i % 4 == 0));
      if (i % 4 == 0) check("p0_data", d_a, i);
      check("p0_count_le1", (c_a <= 5'd1), 1);
      check("p3_valid", v_b, (i % 4 == 3));
      if (i % 4 == 3) check("p3_data", d_b, i);
      check("d1_data", d_c, i);
      check("d1_count", c_c, 1);
    end
    ena = 1'b0;
    tick();
    do_clear();

    // Enable toggling: only enabled samples advance the phase.
    en_idx = 0;
    for (int i = 0; i < 16; i++) begin
      ena  = (i % 2 == 0);
      data = 8'(i);
      tick();
      if (i % 2 == 0) begin
        check("tog_p0_valid", v_a, (en_idx % 4 == 0));
        if (en_idx % 4 == 0) check("tog_p0_data", d_a, i);
        check("tog_p3_valid", v_b, (en_idx % 4 == 3));
        if (en_idx % 4 == 3) check("tog_p3_data", d_b, i);
        en_idx++;
      end else begin
        check("tog_p0_idle", v_a, 0);
        check("tog_p3_idle", v_b, 0);
      end
    end

    // DECIM=1 fill past capacity with consumer stalled, then drain.
    ena   = 1'b0;
    ready = 1'b0;
    do_clear();
    for (int k = 1; k <= 20; k++) begin
      ena  = 1'b1;
      data = 8'(k);
      tick();
      check("fill_count", c_c, (k < 16) ? k : 16);
      check("fill_ovf",   o_c, (k >= 17));
    end
    check("fill_head", d_c, 1);
    ena   = 1'b0;
    ready = 1'b1;
    for (int j = 1; j <= 16; j++) begin
      check("drain_valid", v_c, 1);
      check("drain_data",  d_c, j);
      tick();
      check("drain_count", c_c, 16 - j);
    end
    check("drain_empty", v_c, 0);
    check("drain_ovf_sticky", o_c, 1);

    // Full FIFO with a same-cycle pop must accept the kept sample.
    ready = 1'b0;
    do_clear();
    check("clr_ovf", o_c, 0);
    for (int k = 0; k < 16; k++) begin
      ena  = 1'b1;
      data = 8'(100 + k);
      tick();
    end
    check("full_count", c_c, 16);
    data  = 8'd116;
    ready = 1'b1;
    tick();
    check("fullpop_count", c_c, 16);
    check("fullpop_ovf",   o_c, 0);
    check("fullpop_head",  d_c, 101);
    ena = 1'b0;
    for (int j = 1; j <= 16; j++) begin
      check("fullpop_order", d_c, 100 + j);
      tick();
    end
    check("fullpop_empty", v_c, 0);

    // Clear with five entries, coincident with a kept sample and a pop.
    ready = 1'b0;
    do_clear();
    for (int k = 1; k <= 5; k++) begin
      ena  = 1'b1;
      data = 8'(k);
      tick();
    end
    check("pre_clr_count", c_c, 5);
    clear = 1'b1;
    data  = 8'd99;
    ready = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_count", c_c, 0);
    check("clr_valid", v_c, 0);
    check("clr_ovf2",  o_c, 0);
    check("clr_count_p0", c_a, 0);
    data = 8'd50;
    tick();
    check("post_clr_p0_valid", v_a, 1);
    check("post_clr_p0_data",  d_a, 50);
    check("post_clr_p3_valid", v_b, 0);
    check("post_clr_d1_data",  d_c, 50);
    ena = 1'b0;
    tick();

    // Asynchronous reset between edges with seven entries buffered.
    ready = 1'b0;
    do_clear();
    for (int k = 0; k < 7; k++) begin
      ena  = 1'b1;
      data = 8'(10 + k);
      tick();
    end
    ena = 1'b0;
    check("pre_rst_count", c_c, 7);
    check("pre_rst_valid", v_c, 1);
    #3;
    rst = 1'b1;
    #1;
    check("arst_valid", v_c, 0);
    check("arst_count", c_c, 0);
    check("arst_ovf",   o_c, 0);
    check("arst_data",  d_c, 0);
    check("arst_count_p0", c_a, 0);
    #2;
    rst = 1'b0;
    ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ena  = 1'b1;
      data = 8'(20 + i);
      tick();
      check("rst_restart_p0_valid", v_a, (i % 4 == 0));
      if (i % 4 == 0) check("rst_restart_p0_data", d_a, 20 + i);
      check("rst_restart_p3_valid", v_b, (i == 3));
      if (i == 3) check("rst_restart_p3_data", d_b, 23);
    end
    ena = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
